useq_sequencer: RTL

- Parametrised microsequencer generating the control-unit micro-address `q` each cycle.
- Successor to the fixed-width clear/load/increment control-unit counter.
- Adds:
  - a writable opcode→address map table
  - conditional and unconditional micro-jumps
  - a micro-subroutine call/return stack with error flags
- Sits between the instruction register (opcode) and the microcode ROM (addressed by `q`).

---
 rtl/useq_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/useq_sequencer.sv
// Microsequencer: produces the micro-address q from a writable opcode map, micro-jumps,
// and a bounded call/return stack with sticky overflow/underflow flagging.
module useq_sequencer #(
  parameter int OPCODE_BITS = 2,
  parameter int N           = 4,
  parameter int DEPTH       = 2,
  parameter int MAP_BASE    = 3,
  parameter int MAP_STRIDE  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [2:0]             sel,
  input  logic [OPCODE_BITS-1:0] opcode,
  input  logic [N-1:0]           jmp_addr,
  input  logic                   cond,
  input  logic                   map_we,
  input  logic [OPCODE_BITS-1:0] map_idx,
  input  logic [N-1:0]           map_wdata,
  output logic [N-1:0]           q,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic                   err
);

  typedef enum logic [2:0] {
    SEL_HOLD = 3'b000,
    SEL_INC  = 3'b001,
    SEL_MAP  = 3'b010,
    SEL_JMP  = 3'b011,
    SEL_CJMP = 3'b100,
    SEL_CALL = 3'b101,
    SEL_RET  = 3'b110,
    SEL_RSVD = 3'b111
  } sel_e;

  localparam int MAP_ENTRIES = 1 << OPCODE_BITS;
  localparam int SPW         = $clog2(DEPTH + 1);
  // Storage is rounded up to a power of two so the pointer indexes it at full width.
  localparam int SLOTS       = 1 << SPW;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [N-1:0]   map_q [MAP_ENTRIES];
  logic [N-1:0]   stk_q [SLOTS];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] top_idx;
  logic [N-1:0]   q_inc;
  logic [N-1:0]   q_nxt;
  logic           push;
  logic           pop;
  logic           err_set;

  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);
  assign top_idx     = sp_q - SPW'(1);
  assign q_inc       = q + N'(1);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    q_nxt   = q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (en) begin
      unique case (sel_e'(sel))
        SEL_HOLD: q_nxt = q;
        SEL_INC:  q_nxt = q_inc;
        SEL_MAP:  q_nxt = map_q[opcode];
        SEL_JMP:  q_nxt = jmp_addr;
        SEL_CJMP: q_nxt = cond ? jmp_addr : q_inc;
        SEL_CALL: begin
          if (stack_full) begin
            err_set = 1'b1;
          end else begin
            push  = 1'b1;
            q_nxt = jmp_addr;
          end
        end
        SEL_RET: begin
          if (stack_empty) begin
            err_set = 1'b1;
          end else begin
            pop   = 1'b1;
            q_nxt = stk_q[top_idx];
          end
        end
        SEL_RSVD: q_nxt = q;
        default:  q_nxt = q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      sp_q <= '0;
      err  <= 1'b0;
    end else begin
      q <= q_nxt;
      if (clr)       sp_q <= '0;
      else if (push) sp_q <= sp_q + SPW'(1);
      else if (pop)  sp_q <= top_idx;
      if (err_set)   err  <= 1'b1;
    end
  end

  // NOTE: the map has architected reset contents, so it is reset; the stack storage is not, since the pointer alone defines which entries are valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAP_ENTRIES; i++) begin
        map_q[i] <= N'(MAP_BASE + i * MAP_STRIDE);
      end
    end else if (map_we) begin
      map_q[map_idx] <= map_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk_q[sp_q] <= q_inc;
  end

endmodule
